wash_sequencer: RTL and testbench



---
 rtl/wash_sequencer.sv | 144 ++++++++++++++
 tb/tb_wash_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Table-driven carwash program sequencer: per-program step mask, shared per-step durations,
// built-in one-second prescaler. Define WASH_PAUSE_EN to add the pause/paused ports.
module wash_sequencer #(
  parameter int NUM_STEPS = 14,
  parameter int NUM_PROGS = 4,
  parameter int TIME_W    = 8,
  parameter int PRESCALE  = 1000,
  parameter int STEP_W    = $clog2(NUM_STEPS),
  parameter int PROG_W    = $clog2(NUM_PROGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROG_W-1:0] prog_sel,
  input  logic              start,
  input  logic              pay_ok,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [PROG_W-1:0] cfg_prog,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_en,
  input  logic [TIME_W-1:0] cfg_time,
`ifdef WASH_PAUSE_EN
  input  logic              pause,
  output logic              paused,
`endif
  output logic              busy,
  output logic              step_active,
  output logic [STEP_W-1:0] cur_step,
  output logic [TIME_W-1:0] sec_left,
  output logic              done,
  output logic              aborted
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, SEEK, RUN, DONE} state_t;

  state_t                          state;
  logic [NUM_PROGS-1:0][NUM_STEPS-1:0] mask;
  logic [NUM_STEPS-1:0][TIME_W-1:0]    dur;
  logic [PROG_W-1:0]               prog_q;
  logic [STEP_W-1:0]               step_idx;
  logic [PRE_W-1:0]                presc;
  logic                            stall;
  logic                            cfg_ok, sel_ok, last, tick;

  assign cfg_ok = (32'(cfg_step) < NUM_STEPS) && (32'(cfg_prog) < NUM_PROGS);
  assign sel_ok = (prog_sel != '0) && (32'(prog_sel) < NUM_PROGS);
  assign last   = (step_idx == STEP_W'(NUM_STEPS-1));
  assign tick   = (presc == PRE_W'(PRESCALE-1));

`ifdef WASH_PAUSE_EN
  assign stall  = pause && (state == RUN);
  assign paused = stall;
`else
  assign stall  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= '0;
      dur         <= '0;
      prog_q      <= '0;
      step_idx    <= '0;
      presc       <= '0;
      busy        <= 1'b0;
      step_active <= 1'b0;
      cur_step    <= '0;
      sec_left    <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort && state != IDLE) begin
        // abort outranks every other transition, including the step into DONE
        state       <= IDLE;
        aborted     <= 1'b1;
        busy        <= 1'b0;
        step_active <= 1'b0;
        cur_step    <= '0;
        sec_left    <= '0;
        presc       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we && cfg_ok) begin
              mask[cfg_prog][cfg_step] <= cfg_en;
              dur[cfg_step]            <= cfg_time;
            end
            if (start && pay_ok && sel_ok) begin
              prog_q   <= prog_sel;
              step_idx <= '0;
              busy     <= 1'b1;
              state    <= SEEK;
            end
          end
          SEEK: begin
            if (mask[prog_q][step_idx] && dur[step_idx] != '0) begin
              sec_left    <= dur[step_idx];
              presc       <= '0;
              step_active <= 1'b1;
              cur_step    <= step_idx;
              state       <= RUN;
            end else if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step_idx <= step_idx + 1'b1;
            end
          end
          RUN: begin
            if (!stall) begin
              if (tick) begin
                presc <= '0;
                if (sec_left == TIME_W'(1)) begin
                  sec_left    <= '0;
                  step_active <= 1'b0;
                  cur_step    <= '0;
                  if (last) begin
                    done  <= 1'b1;
                    state <= DONE;
                  end else begin
                    step_idx <= step_idx + 1'b1;
                    state    <= SEEK;
                  end
                end else begin
                  sec_left <= sec_left - 1'b1;
                end
              end else begin
                presc <= presc + 1'b1;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: a program-level model expands each run into the
// expected per-cycle output trace; a negedge monitor pops and compares whenever the DUT is active.
module tb_wash_sequencer;
  localparam int NS = 14, NP = 4, TW = 8, P = 4;
  localparam int SW = $clog2(NS), PW = $clog2(NP);

  logic          clk = 0, reset = 1;
  logic [PW-1:0] prog_sel = 0, cfg_prog = 0;
  logic          start = 0, pay_ok = 0, abort = 0, cfg_we = 0, cfg_en = 0;
  logic [SW-1:0] cfg_step = 0;
  logic [TW-1:0] cfg_time = 0;
  logic          busy, step_active, done, aborted;
  logic [SW-1:0] cur_step;
  logic [TW-1:0] sec_left;
`ifdef WASH_PAUSE_EN
  logic          pause = 0;
  logic          paused;
`endif

  wash_sequencer #(.NUM_STEPS(NS), .NUM_PROGS(NP), .TIME_W(TW), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .prog_sel(prog_sel), .start(start), .pay_ok(pay_ok),
    .abort(abort), .cfg_we(cfg_we), .cfg_prog(cfg_prog), .cfg_step(cfg_step),
    .cfg_en(cfg_en), .cfg_time(cfg_time),
`ifdef WASH_PAUSE_EN
    .pause(pause), .paused(paused),
`endif
    .busy(busy), .step_active(step_active), .cur_step(cur_step), .sec_left(sec_left),
    .done(done), .aborted(aborted));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy, act;
    logic [SW-1:0] step;
    logic [TW-1:0] sec;
    logic          done, ab;
  } obs_t;

  obs_t exp_q[$];
  obs_t tl[$];
  int   errors = 0, checks = 0;
  bit   m_mask[NP][NS];
  int   m_dur[NS];

  function automatic obs_t mk(bit b, bit a, int s, int sec, bit d, bit ab);
    obs_t o;
    o.busy = b; o.act = a; o.step = SW'(s); o.sec = TW'(sec); o.done = d; o.ab = ab;
    return o;
  endfunction

  // Each examined step costs one cycle; an enabled non-zero step then holds dur*P cycles.
  function automatic void build(int prog);
    tl.delete();
    for (int s = 0; s < NS; s++) begin
      tl.push_back(mk(1, 0, 0, 0, 0, 0));
      if (m_mask[prog][s] && m_dur[s] != 0)
        for (int j = 0; j < m_dur[s] * P; j++)
          tl.push_back(mk(1, 1, s, m_dur[s] - j / P, 0, 0));
    end
    tl.push_back(mk(1, 0, 0, 0, 1, 0));
  endfunction

  function automatic void m_write(int p, int s, bit en, int t);
    if (p < NP && s < NS) begin
      m_mask[p][s] = en;
      m_dur[s] = t;
    end
  endfunction

  function automatic void m_clear();
    for (int p = 0; p < NP; p++) for (int s = 0; s < NS; s++) m_mask[p][s] = 0;
    for (int s = 0; s < NS; s++) m_dur[s] = 0;
  endfunction

  always @(negedge clk) begin
    obs_t o, e;
    if (busy || step_active || done || aborted) begin
      o = {busy, step_active, cur_step, sec_left, done, aborted};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got busy=%0d act=%0d step=%0d sec=%0d done=%0d ab=%0d, expected idle",
                 o.busy, o.act, o.step, o.sec, o.done, o.ab);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL trace got busy=%0d act=%0d step=%0d sec=%0d done=%0d ab=%0d want busy=%0d act=%0d step=%0d sec=%0d done=%0d ab=%0d",
                   o.busy, o.act, o.step, o.sec, o.done, o.ab, e.busy, e.act, e.step, e.sec, e.done, e.ab);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(int p, int s, bit en, int t);
    cfg_we = 1; cfg_prog = PW'(p); cfg_step = SW'(s); cfg_en = en; cfg_time = TW'(t);
    tick();
    cfg_we = 0;
    m_write(p, s, en, t);
  endtask

  task automatic check_idle(string name);
    checks++;
    if (busy !== 1'b0 || step_active !== 1'b0 || cur_step !== '0 || sec_left !== '0 ||
        done !== 1'b0 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL %s got busy=%0d act=%0d step=%0d sec=%0d done=%0d ab=%0d, want all 0",
               name, busy, step_active, cur_step, sec_left, done, aborted);
    end
  endtask

  // mode: 0 plain, 1 cfg write in the start cycle, 2 cfg write while running (dropped)
  task automatic run(int prog, bit pay, int abort_at, int reset_at, int mode,
                     int cp, int cs, bit ce, int ct);
    bit acc;
    int cut;
    acc = pay && prog != 0 && prog < NP;
    if (mode == 1) begin
      cfg_we = 1; cfg_prog = PW'(cp); cfg_step = SW'(cs); cfg_en = ce; cfg_time = TW'(ct);
      m_write(cp, cs, ce, ct);
    end
    if (acc) begin
      build(prog);
      cut = (abort_at >= 0) ? abort_at : (reset_at >= 0) ? reset_at : tl.size() - 1;
      for (int i = 0; i <= cut; i++) exp_q.push_back(tl[i]);
      if (abort_at >= 0) exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    end
    start = 1; pay_ok = pay; prog_sel = PW'(prog);
    tick();
    start = 0; pay_ok = 0; cfg_we = 0;
    if (!acc) begin
      repeat (3) tick();
      check_idle("ignored_start");
      return;
    end
    tick();
    if (mode == 2) begin
      cfg_we = 1; cfg_prog = PW'(cp); cfg_step = SW'(cs); cfg_en = ce; cfg_time = TW'(ct);
    end
    tick();
    cfg_we = 0;
    if (abort_at >= 0) begin
      repeat (abort_at - 2) tick();
      abort = 1; tick(); abort = 0;
    end else if (reset_at >= 0) begin
      repeat (reset_at - 2) tick();
      reset = 1; tick(); reset = 0;
      m_clear();
    end
    for (int n = 0; n < 600 && exp_q.size() != 0; n++) tick();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout pending=%0d expected outputs never appeared", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
    check_idle("post_run_idle");
  endtask

  initial begin
    int prog, ab, nw;
    m_clear();
    repeat (3) tick();
    check_idle("reset_state");
    reset = 0;
    tick();
    check_idle("after_reset");

    run(1, 0, -1, -1, 0, 0, 0, 0, 0);
    run(0, 1, -1, -1, 0, 0, 0, 0, 0);

    cfg(1, 0, 1, 3);
    cfg(1, 2, 1, 2);
    run(1, 1, -1, -1, 2, 1, 2, 1, 9);
    cfg(2, 5, 1, 0);
    cfg(2, 6, 1, 1);
    run(2, 1, -1, -1, 0, 0, 0, 0, 0);
    run(1, 1, 6, -1, 0, 0, 0, 0, 0);
    run(1, 1, -1, -1, 0, 0, 0, 0, 0);
    run(3, 1, -1, -1, 0, 0, 0, 0, 0);
    cfg(3, 14, 1, 2);
    run(3, 1, -1, -1, 1, 3, 15, 1, 3);
    run(3, 1, -1, -1, 1, 3, 13, 1, 1);
    run(1, 1, -1, 5, 0, 0, 0, 0, 0);
    run(1, 1, -1, -1, 0, 0, 0, 0, 0);

    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        cfg($urandom_range(0, NP-1), $urandom_range(0, 15), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 3));
      prog = $urandom_range(0, NP-1);
      build(prog);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(3, tl.size() - 2) : -1;
      run(prog, ($urandom_range(0, 7) != 0), ab, -1, $urandom_range(0, 2),
          $urandom_range(0, NP-1), $urandom_range(0, 15), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
